// File: rtl/alu_pipe.sv
// alu_pipe: single-result ALU with valid/ready handshakes on both sides.
//
// Optional feature macro: ALU_PIPE_MUL_EN
//   defined   -> f=011 is an iterative unsigned shift-add multiply (WIDTH cycles)
//   undefined -> f=011 is an illegal opcode (err=1, y=0)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid          in_ready   request accepted this cycle
//   a, b       WIDTH-bit operands     f          3-bit opcode
//   out_valid  result held            out_ready  consumer takes result
//   y          WIDTH-bit result
//   zero       y == 0                 carry      carry-out / no-borrow / MUL high half nonzero
//   ovf        signed overflow        err        illegal opcode
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_MUL  = 3'b011,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } op_e;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, MUL} state_e;
`else
  typedef enum logic {IDLE} state_e;
`endif

  state_e state_q, state_d;
  op_e    op;

  logic rdy_q;      // low in reset, high from the first edge after release
  logic accept;
  logic drain;
  logic load_alu;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_o;
  logic             alu_e;

  assign op     = op_e'(f);
  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Single-cycle ALU; results are zero-filled by default so the illegal
  // opcode case naturally yields y=0 with clear flags.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    alu_y = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    alu_e = 1'b0;
    case (op)
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_ANDN: alu_y = a & ~b;
      OP_ORN:  alu_y = a | ~b;
      OP_ADD: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_o = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = dif[WIDTH-1:0];
        alu_c = ~dif[WIDTH];  // no borrow means a >= b
        alu_o = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  alu_e = 1'b0;  // handled by the multiplier path
`else
      OP_MUL:  alu_e = 1'b1;
`endif
      default: alu_e = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               start_mul;
  logic               mul_done;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   mplier_q;

  assign start_mul = accept && (op == OP_MUL);
  assign load_alu  = accept && (op != OP_MUL);

  // One partial product per MUL cycle; the last one is folded in
  // combinationally so the product lands exactly WIDTH edges after accept.
  assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done = (state_q == MUL) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start_mul) begin
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
    end else if (state_q == MUL) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      acc_q    <= acc_nx;
      mplier_q <= mplier_q >> 1;
    end
  end
`else
  assign load_alu = accept;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
`ifdef ALU_PIPE_MUL_EN
    unique case (state_q)
      IDLE: if (start_mul) state_d = MUL;
      MUL:  if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
`endif
  end

  // FSM: outputs
  always_comb begin
    in_ready = rdy_q && (state_q == IDLE) && (!out_valid || out_ready);
  end

  // Result register; holds while out_valid && !out_ready because it is only
  // written on acceptance or product completion, both blocked by in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_alu) begin
      y         <= alu_y;
      carry     <= alu_c;
      ovf       <= alu_o;
      err       <= alu_e;
      out_valid <= 1'b1;
`ifdef ALU_PIPE_MUL_EN
    end else if (mul_done) begin
      y         <= acc_nx[WIDTH-1:0];
      carry     <= |acc_nx[2*WIDTH-1:WIDTH];
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b1;
`endif
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  assign zero = (y == '0);

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 f  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 MUL, 100 AND-NOT (a&~b), 101 OR-NOT (a|~b), 110 SUB, 111 SLT (signed).
REQ-008 out_valid  output  1  result register holds unconsumed result.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 y  output  WIDTH  result.
REQ-011 zero, carry, ovf, err  output  1 each  y==0; unsigned carry/no-borrow; signed overflow; illegal opcode.

Function
REQ-012 Request accepted on a rising edge where in_valid && in_ready; result accepted where out_valid && out_ready.
REQ-013 in_ready = (state==IDLE) && (!out_valid || out_ready); same-edge drain-and-accept is legal.
REQ-014 States: IDLE, MUL; IDLE->MUL on accepted f=011 (when MUL compiled in); MUL->IDLE on the edge writing the product.
REQ-015 Non-MUL ops: y and flags registered on the acceptance edge; out_valid high from that edge (1-cycle latency).
REQ-016 ADD: y = (a+b) mod 2^WIDTH; carry = carry-out; ovf = signed overflow.
REQ-017 SUB: y = (a-b) mod 2^WIDTH; carry = 1 iff a>=b unsigned; ovf = signed overflow.
REQ-018 SLT: y = 1 iff $signed(a) < $signed(b), else 0, zero-extended; carry=ovf=0.
REQ-019 Logic ops: carry=ovf=0.
REQ-020 zero = (y == 0) for every result, computed from the registered y.
REQ-021 err = 1 only for an illegal opcode; err=1 forces y=0, zero=1, carry=ovf=0; out_valid still asserts with 1-cycle latency.
REQ-022 y, flags and out_valid stay stable while out_valid && !out_ready.
REQ-023 out_valid falls on the drain edge unless a new result is written on that same edge.
REQ-024 a, b, f are sampled only on the acceptance edge; later changes are ignored.

Reset
REQ-025 rst_n low asynchronously forces state=IDLE, out_valid=0, y=0, zero=1, carry=ovf=err=0, and clears the MUL counter and partial product.
REQ-026 Reset during MUL discards the operation; no result appears after release.
REQ-027 in_ready is 0 while rst_n is low and 1 on the first edge after release.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN compiled in: f=011 is an iterative shift-add unsigned multiply, one partial product per cycle.
REQ-029 Multiply: product register written on the edge WIDTH cycles after acceptance; y = low WIDTH bits of a*b; carry = 1 iff the high WIDTH bits are nonzero; ovf=0; in_ready=0 throughout.
REQ-030 Macro not defined: no MUL state or multiplier logic; f=011 is illegal per REQ-021.

Verification
REQ-031 WIDTH=32, SUB a=5 b=7 -> y=0xFFFFFFFE, carry=0, ovf=0, zero=0, out_valid one edge after acceptance.
REQ-032 ADD a=0x7FFFFFFF b=1 -> y=0x80000000, ovf=1, carry=0; ADD a=0xFFFFFFFF b=1 -> y=0, carry=1, zero=1.
REQ-033 SLT a=0xFFFFFFFF b=1 -> y=1; SUB a=b=0x1234 -> y=0, zero=1, carry=1.
REQ-034 Backpressure: out_ready low 3 cycles with in_valid held -> in_ready=0, y stable; second op accepted on the edge out_ready rises, new y visible after it.
REQ-035 MUL_EN defined: MUL a=0x00010000 b=0x00010003 -> y=0x00030000, carry=1, out_valid exactly 32 edges after acceptance; undefined -> y=0, err=1 after 1 edge.
REQ-036 rst_n pulsed low 10 cycles into MUL -> out_valid=0, in_ready=1 on the first edge after release, no stale result.
